// File: rtl/wb_bus_arb_ctrl.sv
// Round-robin arbiter that lets N Wishbone B3 masters share one slave port.
// A stalled strobe that gets no response within TIMEOUT cycles is aborted with an error to the owner.
module wb_bus_arb_ctrl #(
  parameter int N       = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N-1:0]        m_cyc_i,
  input  logic [N-1:0]        m_stb_i,
  input  logic [N-1:0]        m_we_i,
  input  logic [N*AW-1:0]     m_adr_i,
  input  logic [N*DW-1:0]     m_dat_i,
  input  logic [N*DW/8-1:0]   m_sel_i,
  output logic [N-1:0]        m_ack_o,
  output logic [N-1:0]        m_err_o,
  output logic [DW-1:0]       m_dat_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [AW-1:0]       s_adr_o,
  output logic [DW-1:0]       s_dat_o,
  output logic [DW/8-1:0]     s_sel_o,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  input  logic [DW-1:0]       s_dat_i,
  output logic [N-1:0]        gnt_o
);
  localparam int SW = DW/8;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN   = 2'd1;
  localparam logic [1:0] ABORT = 2'd2;
  localparam logic [15:0] TO16    = TIMEOUT[15:0];
  localparam logic [N-1:0] GNT_RST = {1'b1, {(N-1){1'b0}}};

  logic [1:0]    state;
  logic [N-1:0]  gnt, nxt_gnt;
  logic [15:0]   stall_cnt;
  logic          own_st, abort_st, stalled;
  logic          own_cyc, own_stb, own_we;
  logic [AW-1:0] own_adr;
  logic [DW-1:0] own_dat;
  logic [SW-1:0] own_sel;

  // gnt is one-hot, so the owner mux is a plain select loop
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt[k]) begin
        own_cyc = m_cyc_i[k];
        own_stb = m_stb_i[k];
        own_we  = m_we_i[k];
        own_adr = m_adr_i[k*AW +: AW];
        own_dat = m_dat_i[k*DW +: DW];
        own_sel = m_sel_i[k*SW +: SW];
      end
    end
  end

  // Lowest requester above the current owner wins; otherwise lowest at or below it.
  always_comb begin
    int g;
    g = 0;
    for (int k = 0; k < N; k++)
      if (gnt[k]) g = k;
    nxt_gnt = gnt;
    for (int k = N-1; k >= 0; k--)
      if (m_cyc_i[k] && k <= g) begin
        nxt_gnt    = '0;
        nxt_gnt[k] = 1'b1;
      end
    for (int k = N-1; k >= 0; k--)
      if (m_cyc_i[k] && k > g) begin
        nxt_gnt    = '0;
        nxt_gnt[k] = 1'b1;
      end
  end

  assign stalled = own_stb & ~s_ack_i & ~s_err_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      gnt       <= GNT_RST;
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (|m_cyc_i) begin
            gnt   <= nxt_gnt;
            state <= OWN;
          end
        end
        OWN: begin
          if (!own_cyc) begin
            state     <= IDLE;
            stall_cnt <= '0;
          end else if (stalled) begin
            if (stall_cnt == TO16) begin
              state     <= ABORT;
              stall_cnt <= '0;
            end else begin
              stall_cnt <= stall_cnt + 16'd1;
            end
          end else begin
            stall_cnt <= '0;
          end
        end
        ABORT: begin
          state     <= IDLE;
          stall_cnt <= '0;
        end
        default: begin
          state     <= IDLE;
          stall_cnt <= '0;
        end
      endcase
    end
  end

  // Gating with rst_i keeps the slave request and responses quiet while reset is held.
  assign own_st   = (state == OWN)   & ~rst_i;
  assign abort_st = (state == ABORT) & ~rst_i;

  assign s_cyc_o = own_st & own_cyc;
  assign s_stb_o = own_st & own_stb;
  assign s_we_o  = own_we;
  assign s_adr_o = own_adr;
  assign s_dat_o = own_dat;
  assign s_sel_o = own_sel;
  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt;

  for (genvar k = 0; k < N; k++) begin : g_resp
    assign m_ack_o[k] = gnt[k] & own_st & s_ack_i & ~s_err_i;
    assign m_err_o[k] = gnt[k] & ((own_st & s_err_i) | abort_st);
  end

endmodule

// File: tb/tb_wb_bus_arb_ctrl.sv
// Scoreboard bench for wb_bus_arb_ctrl: directed scenarios followed by randomized traffic,
// checked against a cycle-level owner/timeout model.
module tb_wb_bus_arb_ctrl;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW/8;
  localparam int TO = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      m_cyc, m_stb, m_we, m_ack, m_err, gnt;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_dat;
  logic [N*SW-1:0]   m_sel;
  logic [DW-1:0]     m_rdat, s_wdat, s_rdat;
  logic              s_cyc, s_stb, s_we, s_ack, s_err;
  logic [AW-1:0]     s_adr;
  logic [SW-1:0]     s_sel;

  always #5 clk = ~clk;

  wb_bus_arb_ctrl #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_rdat),
    .gnt_o(gnt)
  );

  typedef struct {
    logic [N-1:0]  gnt, ack, err;
    logic          scyc, sstb, swe;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic [SW-1:0] sel;
  } cyc_t;

  typedef struct {
    logic [N-1:0]  ack, err;
    logic [DW-1:0] dat;
  } resp_t;

  cyc_t  cq[$];
  resp_t rq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // reference model: owner index, whether it holds the bus, pending abort, stalled-cycle count
  int mo = N-1;
  bit mact = 1'b0;
  bit mab  = 1'b0;
  int mw   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model();
    cyc_t  x;
    resp_t y;
    if (rst) begin
      mo = N-1; mact = 1'b0; mab = 1'b0; mw = 0;
    end
    x = '{default: '0};
    x.gnt = 4'(1 << mo);
    if (!rst && mab) begin
      x.err[mo] = 1'b1;
    end else if (!rst && mact) begin
      x.scyc = m_cyc[mo];
      x.sstb = m_stb[mo];
      x.swe  = m_we[mo];
      x.adr  = m_adr[mo*AW +: AW];
      x.wdat = m_dat[mo*DW +: DW];
      x.sel  = m_sel[mo*SW +: SW];
      if (s_err)      x.err[mo] = 1'b1;
      else if (s_ack) x.ack[mo] = 1'b1;
    end
    cq.push_back(x);
    if ((x.ack | x.err) != '0) begin
      y.ack = x.ack; y.err = x.err; y.dat = s_rdat;
      rq.push_back(y);
    end
    if (rst) begin
    end else if (mab) begin
      mab = 1'b0; mact = 1'b0;
    end else if (mact) begin
      if (!m_cyc[mo]) mact = 1'b0;
      else if (m_stb[mo] && !s_ack && !s_err) begin
        if (mw == TO) begin mab = 1'b1; mw = 0; end
        else mw++;
      end else mw = 0;
    end else if (m_cyc != '0) begin
      for (int d = 1; d <= N; d++)
        if (m_cyc[(mo+d)%N]) begin mo = (mo+d)%N; break; end
      mact = 1'b1; mw = 0;
    end
  endtask

  task automatic step(input bit r, input logic [N-1:0] c, input logic [N-1:0] s,
                      input bit a, input bit e);
    @(posedge clk); #1;
    rst   = r;
    m_cyc = c;
    m_stb = c & s;
    m_we  = 4'($urandom);
    m_adr = {$urandom, $urandom};
    m_dat = {$urandom, $urandom, $urandom, $urandom};
    m_sel = 16'($urandom);
    s_ack = a;
    s_err = e;
    s_rdat = $urandom;
    model();
  endtask

  // monitor: per-cycle bus checks plus response scoreboard
  initial begin
    cyc_t  x;
    resp_t y;
    forever begin
      @(negedge clk);
      if (cq.size() > 0) begin
        x = cq.pop_front();
        chk("gnt", gnt, x.gnt);
        chk("s_cyc", s_cyc, x.scyc);
        chk("s_stb", s_stb, x.sstb);
        chk("m_ack", m_ack, x.ack);
        chk("m_err", m_err, x.err);
        if (x.scyc) begin
          chk("s_adr", s_adr, x.adr);
          chk("s_we", s_we, x.swe);
          chk("s_dat", s_wdat, x.wdat);
          chk("s_sel", s_sel, x.sel);
        end
      end
      if ((m_ack | m_err) != '0) begin
        if (rq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL resp: got ack=%b err=%b expected none", m_ack, m_err);
        end else begin
          y = rq.pop_front();
          chk("resp", {m_ack, m_err}, {y.ack, y.err});
          chk("rdata", m_rdat, y.dat);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] rc;
    bit slow;
    rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rdat = '0;

    step(1, 4'b0000, 4'b0000, 1, 1);
    @(negedge clk);
    chk("rst_gnt", gnt, 4'b1000);
    chk("rst_resp", {m_ack, m_err, s_cyc, s_stb}, 10'd0);

    // first grant goes to the lowest requester after reset
    step(0, 4'b1010, 4'b0000, 0, 0);
    step(0, 4'b1010, 4'b0010, 0, 0);
    @(negedge clk);
    chk("first_gnt", gnt, 4'b0010);
    chk("first_scyc", s_cyc, 1'b1);
    step(0, 4'b1010, 4'b0010, 1, 0);
    step(0, 4'b0000, 4'b0000, 0, 0);
    step(0, 4'b0100, 4'b0000, 0, 0);
    step(0, 4'b0000, 4'b0000, 0, 0);

    // round robin from gnt=0100 with masters 1 and 3 requesting
    step(0, 4'b1010, 4'b0000, 0, 0);
    step(0, 4'b1010, 4'b1000, 1, 0);
    @(negedge clk); chk("rr_a", gnt, 4'b1000);
    step(0, 4'b0010, 4'b0000, 0, 0);
    step(0, 4'b1010, 4'b0000, 0, 0);
    step(0, 4'b1010, 4'b0010, 1, 0);
    @(negedge clk); chk("rr_b", gnt, 4'b0010);
    step(0, 4'b1000, 4'b0000, 0, 0);
    step(0, 4'b1010, 4'b0000, 0, 0);
    step(0, 4'b1010, 4'b1000, 1, 0);
    @(negedge clk); chk("rr_c", gnt, 4'b1000);
    step(0, 4'b0000, 4'b0000, 0, 0);

    // timeout: four stalled strobes, abort on the fifth with a late ack dropped
    step(0, 4'b0001, 4'b0000, 0, 0);
    repeat (4) step(0, 4'b0001, 4'b0001, 0, 0);
    step(0, 4'b0001, 4'b0001, 1, 0);
    @(negedge clk);
    chk("to_err", m_err, 4'b0001);
    chk("to_ack", m_ack, 4'b0000);
    chk("to_scyc_abort", s_cyc, 1'b0);
    step(0, 4'b0001, 4'b0000, 1, 0);
    @(negedge clk); chk("to_scyc_idle", s_cyc, 1'b0);
    step(0, 4'b0001, 4'b0000, 0, 0);

    // locked transfer: master 2 waits until master 0 releases cyc
    repeat (3) begin
      step(0, 4'b0101, 4'b0001, 1, 0);
      @(negedge clk); chk("lock_gnt", gnt, 4'b0001);
      step(0, 4'b0101, 4'b0000, 0, 0);
    end
    step(0, 4'b0100, 4'b0000, 0, 0);
    @(negedge clk); chk("lock_fall", gnt, 4'b0001);
    step(0, 4'b0100, 4'b0000, 0, 0);
    @(negedge clk); chk("lock_dead", gnt, 4'b0001);
    step(0, 4'b0100, 4'b0100, 0, 0);
    @(negedge clk); chk("lock_new", gnt, 4'b0100);

    // reset mid-transfer with an ack on the bus
    step(0, 4'b0100, 4'b0100, 0, 0);
    step(1, 4'b0100, 4'b0100, 1, 0);
    @(negedge clk);
    chk("mid_rst_scyc", s_cyc, 1'b0);
    chk("mid_rst_gnt", gnt, 4'b1000);
    chk("mid_rst_ack", m_ack, 4'b0000);
    step(0, 4'b0000, 4'b0000, 0, 0);

    // simultaneous ack and err: err only
    step(0, 4'b0001, 4'b0000, 0, 0);
    step(0, 4'b0001, 4'b0001, 1, 1);
    @(negedge clk);
    chk("both_err", m_err, 4'b0001);
    chk("both_ack", m_ack, 4'b0000);
    step(0, 4'b0000, 4'b0000, 0, 0);

    // randomized traffic with slow/fast slave phases and rare resets
    rc = '0;
    for (int i = 0; i < 3000; i++) begin
      slow = ((i / 200) % 2) == 1;
      for (int k = 0; k < N; k++)
        rc[k] = rc[k] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 399) == 0, rc, 4'($urandom),
           $urandom_range(0, slow ? 7 : 1) == 0, $urandom_range(0, 9) == 0);
    end
    repeat (3) step(0, 4'b0000, 4'b0000, 0, 0);
    @(negedge clk); @(negedge clk);
    chk("resp_left", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_bus_arb_ctrl.md
WB_BUS_ARB_CTRL -- requirements
Module: wb_bus_arb_ctrl

Interface
REQ-001 SHALL have parameter N, default 2: number of Wishbone B3 masters sharing one slave port.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width; select width is DW/8.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum stalled strobe cycles before abort, range 1..65535.
REQ-005 SHALL have ports with one clock and an asynchronous, active-high reset:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- m_cyc_i, m_stb_i, m_we_i  in  N  per-master request bits.
- m_adr_i  in  N*AW  per-master addresses; master k occupies bits [k*AW +: AW].
- m_dat_i  in  N*DW  per-master write data.
- m_sel_i  in  N*DW/8  per-master byte selects.
- m_ack_o, m_err_o  out  N  per-master responses.
- m_dat_o  out  DW  read data, broadcast to all masters.
- s_cyc_o, s_stb_o, s_we_o  out  1  slave request.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte selects.
- s_ack_i, s_err_i  in  1  slave responses.
- s_dat_i  in  DW  slave read data.
- gnt_o  out  N  one-hot registered grant.

Function
REQ-006 SHALL implement the state machine IDLE, OWN and ABORT, held in registers.
REQ-007 In IDLE with any m_cyc_i set, SHALL register nxt_gnt and move to OWN on the next edge; with no m_cyc_i set, SHALL hold gnt and stay in IDLE.
REQ-008 nxt_gnt SHALL be the first requesting master at index (g+1), (g+2), ... modulo N, where g is the index of the current gnt (round-robin); g itself SHALL be lowest priority.
REQ-009 gnt SHALL always be one-hot and SHALL change only on the IDLE->OWN transition.
REQ-010 In OWN, the s_* request outputs SHALL combinationally equal the owner's m_* inputs; in IDLE and ABORT, s_cyc_o and s_stb_o SHALL be 0.
REQ-011 In OWN, the slave response SHALL be routed as m_ack_o[owner]=s_ack_i and m_err_o[owner]=s_err_i; all other response bits SHALL be 0.
REQ-012 m_dat_o SHALL equal s_dat_i in every state.
REQ-013 In OWN, when m_cyc_i[owner]=0, SHALL go to IDLE; this gives one dead cycle between owners, so the minimum grant-to-grant spacing is 2 cycles.
REQ-014 A master SHALL keep ownership across multiple strobes while its cyc stays high (locked transfer); no preemption.
REQ-015 A 16-bit stall counter SHALL increment each OWN cycle with s_stb_o=1 and s_ack_i=0 and s_err_i=0; it SHALL clear on ack, on err, on stb low, and on leaving OWN.
REQ-016 When the stall counter equals TIMEOUT and no response arrives, SHALL go to ABORT.
REQ-017 In ABORT (exactly one cycle), SHALL drive m_err_o[owner]=1 and then go to IDLE; a late s_ack_i or s_err_i arriving in ABORT or IDLE SHALL be dropped.
REQ-018 s_ack_i and s_err_i asserted together SHALL forward only err.
REQ-019 When the owner deasserts cyc in the same cycle a response arrives, SHALL still forward the response, then go to IDLE.

Reset
REQ-020 rst_i SHALL asynchronously force state=IDLE, gnt=one-hot bit N-1 (so master 0 wins first), and stall counter=0; all m_ack_o, m_err_o, s_cyc_o and s_stb_o SHALL read 0 while rst_i=1.
REQ-021 Reset asserted mid-transfer SHALL drop s_cyc_o immediately with no response to the master.

Verification
REQ-022 N=4, after reset, m_cyc_i=1010 -> gnt_o=0010 one cycle later, s_cyc_o follows m_cyc_i[1].
REQ-023 N=4, gnt=0100, m_cyc_i=1010, owner releases each grant after one transfer -> grant sequence 1000, 0010, 1000.
REQ-024 TIMEOUT=3, owner strobes, slave never acks -> m_err_o[owner]=1 on the 5th cycle after stb, then s_cyc_o=0 in ABORT and IDLE.
REQ-025 Owner performs 3 strobes with cyc held while another master requests -> no grant change until the owner's cyc falls, then the new grant 2 cycles later.
REQ-026 rst_i pulsed during OWN with stb high -> s_cyc_o=0 the same cycle, gnt_o=1000 (N=4), no ack delivered.
REQ-027 s_ack_i=1 and s_err_i=1 together -> m_err_o[owner]=1 and m_ack_o=0.
